// File: rtl/motor_ctrl_pkg.sv
// Shared scheduler types, default sizing and the saturating error subtract.
package motor_ctrl_pkg;

  localparam int NCH_DEF     = 8;
  localparam int W_DEF       = 32;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ISSUE,
    WAIT,
    APPLY,
    DONE
  } sched_state_t;

  // One extra bit of headroom; clamp when the top two bits disagree.
  function automatic logic [W_DEF-1:0] sat_sub(input logic [W_DEF-1:0] a,
                                               input logic [W_DEF-1:0] b);
    logic [W_DEF:0] d;
    d = {a[W_DEF-1], a} - {b[W_DEF-1], b};
    if (d[W_DEF] != d[W_DEF-1]) begin
      sat_sub = {d[W_DEF], {(W_DEF-1){~d[W_DEF]}}};
    end else begin
      sat_sub = d[W_DEF-1:0];
    end
  endfunction

endpackage

// File: rtl/pid_err_sat.sv
// Signed a - b clamped to the W-bit range; purely combinational, no backpressure.
module pid_err_sat
  import motor_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  if (W == W_DEF) begin : g_pkg
    assign diff_o = sat_sub(a_i, b_i);
  end else begin : g_gen
    logic [W:0] d;
    assign d      = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    assign diff_o = (d[W] != d[W-1]) ? {d[W], {(W-1){~d[W]}}} : d[W-1:0];
  end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Per tick: snapshot errors, then round-robin NCH channels through one shared PID unit.
// Frame = 3 + NCH*(issue wait + rsp wait + 1) cycles; request holds until ready, e_stop aborts.
module pid_channel_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int W           = W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     enable,
  input  logic                     e_stop,
  input  logic [NCH-1:0]           limit,
  input  logic [NCH*W-1:0]         setpoint,
  input  logic [NCH*W-1:0]         position,
  output logic                     pid_req_valid,
  input  logic                     pid_req_ready,
  output logic [$clog2(NCH)-1:0]   pid_req_ch,
  output logic [W-1:0]             pid_req_error,
  input  logic                     pid_rsp_valid,
  input  logic [$clog2(NCH)-1:0]   pid_rsp_ch,
  input  logic [W-1:0]             pid_rsp_corr,
  output logic [NCH*W-1:0]         error_out,
  output logic [NCH*W-1:0]         correction_out,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     timeout_err,
  output logic                     ch_mismatch
);

  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  sched_state_t   state_q, state_d;
  logic [CW-1:0]  ch_q;
  logic [W-1:0]   err_q  [NCH];
  logic [W-1:0]   corr_q [NCH];
  logic [W-1:0]   err_now[NCH];
  logic [W-1:0]   rsp_corr_q;
  logic [TW-1:0]  cnt_q;
  logic           overrun_q;
  logic           timeout_q;
  logic           mismatch_q;

  logic           in_wait;
  logic           rsp_hit;
  logic           rsp_miss;
  logic           tmo_hit;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pid_err_sat #(.W(W)) u_sat (
      .a_i    (setpoint[c*W +: W]),
      .b_i    (position[c*W +: W]),
      .diff_o (err_now[c])
    );
    assign error_out[c*W +: W]      = err_q[c];
    assign correction_out[c*W +: W] = corr_q[c];
  end

  assign in_wait  = (state_q == WAIT);
  assign rsp_hit  = in_wait && pid_rsp_valid && (pid_rsp_ch == ch_q);
  assign rsp_miss = in_wait && pid_rsp_valid && (pid_rsp_ch != ch_q);
  assign tmo_hit  = in_wait && !rsp_hit && (cnt_q == TMO_LAST);

  assign pid_req_ch    = ch_q;
  assign pid_req_error = err_q[ch_q];
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_q;
  assign ch_mismatch   = mismatch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (e_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (tick && enable) state_d = CAPTURE;
        CAPTURE: state_d = ISSUE;
        ISSUE:   if (pid_req_ready) state_d = WAIT;
        WAIT:    if (rsp_hit || tmo_hit) state_d = APPLY;
        APPLY:   state_d = (ch_q == LAST_CH) ? DONE : ISSUE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pid_req_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      CAPTURE, WAIT, APPLY: busy = 1'b1;
      ISSUE: begin
        busy          = 1'b1;
        pid_req_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q       <= '0;
      rsp_corr_q <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      mismatch_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        err_q[c]  <= '0;
        corr_q[c] <= '0;
      end
    end else begin
      if (tick && busy) overrun_q <= 1'b1;
      if (e_stop) begin
        // Immediate kill of the PWM drive; measured errors stay visible.
        ch_q <= '0;
        for (int c = 0; c < NCH; c++) corr_q[c] <= '0;
      end else begin
        case (state_q)
          CAPTURE: begin
            ch_q <= '0;
            for (int c = 0; c < NCH; c++) err_q[c] <= err_now[c];
          end
          ISSUE: cnt_q <= '0;
          WAIT: begin
            cnt_q <= cnt_q + 1'b1;
            if (rsp_miss) mismatch_q <= 1'b1;
            if (rsp_hit) begin
              rsp_corr_q <= pid_rsp_corr;
            end else if (tmo_hit) begin
              rsp_corr_q <= '0;
              timeout_q  <= 1'b1;
            end
          end
          APPLY: begin
            corr_q[ch_q] <= limit[ch_q] ? '0 : rsp_corr_q;
            if (ch_q != LAST_CH) ch_q <= ch_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed bench for pid_channel_scheduler with a behavioural PID stub (corr = 2*err).
module tb_pid_channel_scheduler;

  localparam int NCH = 8;
  localparam int W   = 32;
  localparam int TMO = 1024;

  logic               clk = 1'b0;
  logic               reset;
  logic               tick;
  logic               enable;
  logic               e_stop;
  logic [NCH-1:0]     limit;
  logic [NCH*W-1:0]   setpoint;
  logic [NCH*W-1:0]   position;
  logic               pid_req_valid;
  logic               pid_req_ready;
  logic [2:0]         pid_req_ch;
  logic [W-1:0]       pid_req_error;
  logic               pid_rsp_valid;
  logic [2:0]         pid_rsp_ch;
  logic [W-1:0]       pid_rsp_corr;
  logic [NCH*W-1:0]   error_out;
  logic [NCH*W-1:0]   correction_out;
  logic               busy;
  logic               done;
  logic               overrun;
  logic               timeout_err;
  logic               ch_mismatch;

  int checks = 0;
  int errors = 0;

  // Stub controls, written only by the main sequence.
  logic       stub_on = 1'b0;
  logic       skip_en = 1'b0;
  logic [2:0] skip_ch = 3'd0;
  logic       mm_arm  = 1'b0;

  logic       hs;
  logic [2:0] hs_ch;
  logic [W-1:0] hs_err;

  pid_channel_scheduler #(.NCH(NCH), .W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .enable         (enable),
    .e_stop         (e_stop),
    .limit          (limit),
    .setpoint       (setpoint),
    .position       (position),
    .pid_req_valid  (pid_req_valid),
    .pid_req_ready  (pid_req_ready),
    .pid_req_ch     (pid_req_ch),
    .pid_req_error  (pid_req_error),
    .pid_rsp_valid  (pid_rsp_valid),
    .pid_rsp_ch     (pid_rsp_ch),
    .pid_rsp_corr   (pid_rsp_corr),
    .error_out      (error_out),
    .correction_out (correction_out),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .timeout_err    (timeout_err),
    .ch_mismatch    (ch_mismatch)
  );

  always #5 clk = ~clk;

  // PID stub: answers one cycle after each handshake, optionally skipping a
  // channel or sending a wrong-channel response before the real one for ch1.
  initial begin
    pid_rsp_valid = 1'b0;
    pid_rsp_ch    = 3'd0;
    pid_rsp_corr  = '0;
    forever begin
      @(negedge clk);
      #2;
      hs     = pid_req_valid && pid_req_ready;
      hs_ch  = pid_req_ch;
      hs_err = pid_req_error;
      @(posedge clk);
      #1;
      pid_rsp_valid = 1'b0;
      if (hs && stub_on && !(skip_en && hs_ch == skip_ch)) begin
        if (mm_arm && hs_ch == 3'd1) begin
          pid_rsp_valid = 1'b1;
          pid_rsp_ch    = 3'd7;
          pid_rsp_corr  = 32'h0000_DEAD;
          @(posedge clk);
          #1;
        end
        pid_rsp_valid = 1'b1;
        pid_rsp_ch    = hs_ch;
        pid_rsp_corr  = hs_err << 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] sp, input logic [W-1:0] pos);
    setpoint[c*W +: W] = sp;
    position[c*W +: W] = pos;
  endtask

  function automatic logic [W-1:0] eo(input int c);
    return error_out[c*W +: W];
  endfunction

  function automatic logic [W-1:0] co(input int c);
    return correction_out[c*W +: W];
  endfunction

  // Called at a negedge: pulses tick, optionally re-ticks at step retick_at,
  // and records the first done step and the number of done pulses in the window.
  task automatic frame(input int win, input int retick_at, output int first, output int pulses);
    first  = -1;
    pulses = 0;
    tick   = 1'b1;
    enable = 1'b1;
    for (int n = 1; n <= win; n++) begin
      @(negedge clk);
      tick = (n == retick_at);
      if (done) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    tick = 1'b0;
  endtask

  int first;
  int pulses;
  int steps;
  logic got;

  initial begin
    // Reset with random inputs applied.
    reset         = 1'b1;
    pid_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick          = 1'($urandom);
      enable        = 1'($urandom);
      e_stop        = 1'($urandom);
      limit         = 8'($urandom);
      pid_req_ready = 1'($urandom);
      for (int c = 0; c < NCH; c++) set_ch(c, $urandom, $urandom);
      @(negedge clk);
    end
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_valid", pid_req_valid, 0);
    chk("rst_req_ch", pid_req_ch, 0);
    chk("rst_req_error", pid_req_error, 0);
    chk("rst_error_out", error_out, 0);
    chk("rst_correction_out", correction_out, 0);
    chk("rst_flags", {overrun, timeout_err, ch_mismatch}, 0);

    reset         = 1'b0;
    tick          = 1'b0;
    enable        = 1'b1;
    e_stop        = 1'b0;
    limit         = '0;
    pid_req_ready = 1'b1;
    stub_on       = 1'b1;
    set_ch(0, 32'h7FFF_FFFF, -32'sd10);
    set_ch(1, 32'h8000_0000, 32'd5);
    set_ch(2, 32'd50, 32'd80);
    set_ch(3, 32'd1000, 32'd400);
    set_ch(4, 32'd7, 32'd0);
    set_ch(5, -32'sd100, -32'sd300);
    set_ch(6, 32'd0, 32'd0);
    set_ch(7, 32'd1, 32'd2);
    @(negedge clk);
    chk("idle_no_tick_busy", busy, 0);

    // Frame 1: all channels answer promptly.
    frame(40, 0, first, pulses);
    chk("f1_tick_to_done", first + 1, 27);
    chk("f1_done_pulses", pulses, 1);
    chk("f1_err3", eo(3), 32'd600);
    chk("f1_corr3", co(3), 32'd1200);
    chk("f1_err0_sat_pos", eo(0), 32'h7FFF_FFFF);
    chk("f1_err1_sat_neg", eo(1), 32'h8000_0000);
    chk("f1_corr0", co(0), 32'hFFFF_FFFE);
    chk("f1_err2", eo(2), 32'hFFFF_FFE2);
    chk("f1_corr2", co(2), 32'hFFFF_FFC4);
    chk("f1_corr5", co(5), 32'd400);
    chk("f1_corr7", co(7), 32'hFFFF_FFFE);
    chk("f1_flags", {overrun, timeout_err, ch_mismatch}, 0);
    chk("f1_idle_busy", busy, 0);

    // Frame 2: ch2 never answered, ch5 limit tripped between frames.
    set_ch(5, -32'sd50, -32'sd300);
    limit   = 8'b0010_0000;
    skip_en = 1'b1;
    skip_ch = 3'd2;
    @(negedge clk);
    chk("limit_between_frames_holds", co(5), 32'd400);
    tick  = 1'b1;
    steps = 0;
    got   = 1'b0;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      tick = 1'b0;
      steps++;
      if (timeout_err) begin
        got = 1'b1;
        break;
      end
    end
    chk("tmo_seen", got, 1);
    chk("tmo_steps", steps, 9 + TMO);
    @(negedge clk);
    chk("tmo_next_req_valid", pid_req_valid, 1);
    chk("tmo_next_req_ch", pid_req_ch, 3);
    chk("tmo_corr2_zero", co(2), 0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("f2_done_seen", got, 1);
    chk("f2_corr5_limited", co(5), 0);
    chk("f2_err5_updated", eo(5), 32'd250);
    chk("f2_corr3", co(3), 32'd1200);
    chk("f2_flags", {overrun, timeout_err, ch_mismatch}, 3'b010);
    skip_en = 1'b0;
    limit   = '0;
    @(negedge clk);

    // Frame 3: second tick mid-frame, wrong-channel response while waiting on ch1.
    set_ch(1, 32'd10, 32'd3);
    mm_arm = 1'b1;
    frame(60, 5, first, pulses);
    mm_arm = 1'b0;
    chk("f3_overrun", overrun, 1);
    chk("f3_mismatch", ch_mismatch, 1);
    chk("f3_done_pulses", pulses, 1);
    chk("f3_tick_to_done", first + 1, 28);
    chk("f3_corr1", co(1), 32'd14);
    chk("f3_corr7", co(7), 32'hFFFF_FFFE);
    chk("f3_corr5", co(5), 32'd500);

    // Ticks are ignored while enable is low.
    enable = 1'b0;
    tick   = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("disabled_tick_busy", busy, 0);
    enable = 1'b1;

    // Frame 4: e_stop while ch4 sits in WAIT.
    skip_en = 1'b1;
    skip_ch = 3'd4;
    tick    = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (busy && !pid_req_valid && pid_req_ch == 3'd4) begin
        got = 1'b1;
        break;
      end
    end
    chk("f4_reached_ch4_wait", got, 1);
    e_stop = 1'b1;
    @(negedge clk);
    chk("estop_corr_all_zero", correction_out, 0);
    chk("estop_busy", busy, 0);
    chk("estop_req_valid", pid_req_valid, 0);
    chk("estop_err3_holds", eo(3), 32'd600);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("estop_tick_ignored", busy, 0);
    e_stop  = 1'b0;
    skip_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("estop_release_no_frame", busy, 0);
    chk("estop_release_corr_zero", correction_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
